// File: rtl/inner_product_feeder.sv
// Operand sequencer for the 3-element inner-product unit.
// Streams a buffered u/v vector pair, with v optionally lagging u.
module inner_product_feeder #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    parameter int SKEW  = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_en,
    input  logic [(DEPTH > 1 ? $clog2(DEPTH) : 1)-1:0] wr_addr,
    input  logic [WIDTH-1:0]                      wr_u,
    input  logic [WIDTH-1:0]                      wr_v,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic [WIDTH-1:0]                      u_out,
    output logic                                  u_valid,
    output logic [WIDTH-1:0]                      v_out,
    output logic                                  v_valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int KW = $clog2(DEPTH + SKEW + 1);

    localparam logic [KW-1:0] K_LAST  = KW'(DEPTH + SKEW - 1);
    localparam logic [KW-1:0] K_SKEW  = KW'(SKEW);
    localparam logic [KW-1:0] K_DEPTH = KW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t            state;
    logic [KW-1:0]     k;
    logic [WIDTH-1:0]  u_buf [DEPTH];
    logic [WIDTH-1:0]  v_buf [DEPTH];

    logic [DEPTH-1:0]  wr_hit;
    logic [KW-1:0]     nk;
    logic [KW:0]       vd;
    logic [KW-1:0]     vi;
    logic              u_ok;
    logic              v_ok;
    logic [WIDTH-1:0]  u_sel;
    logic [WIDTH-1:0]  v_sel;

    // Element for the next cycle; a write landing on the start edge is forwarded.
    always_comb begin
        wr_hit = '0;
        u_sel  = '0;
        v_sel  = '0;
        nk     = (state == IDLE) ? '0 : k + 1'b1;
        vd     = {1'b0, nk} - {1'b0, K_SKEW};
        vi     = vd[KW-1:0];
        u_ok   = nk < K_DEPTH;
        v_ok   = !vd[KW] && (vi < K_DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            wr_hit[i] = (state == IDLE) && wr_en && (wr_addr == AW'(i));
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (nk == KW'(i))
                u_sel = wr_hit[i] ? wr_u : u_buf[i];
            if (vi == KW'(i))
                v_sel = wr_hit[i] ? wr_v : v_buf[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            k       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            u_out   <= '0;
            u_valid <= 1'b0;
            v_out   <= '0;
            v_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                u_buf[i] <= '0;
                v_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i]) begin
                    u_buf[i] <= wr_u;
                    v_buf[i] <= wr_v;
                end
            end
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= STREAM;
                        k       <= '0;
                        busy    <= 1'b1;
                        u_valid <= u_ok;
                        u_out   <= u_ok ? u_sel : '0;
                        v_valid <= v_ok;
                        v_out   <= v_ok ? v_sel : '0;
                    end
                end
                STREAM: begin
                    if (k == K_LAST) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        u_valid <= 1'b0;
                        u_out   <= '0;
                        v_valid <= 1'b0;
                        v_out   <= '0;
                    end else begin
                        k       <= nk;
                        u_valid <= u_ok;
                        u_out   <= u_ok ? u_sel : '0;
                        v_valid <= v_ok;
                        v_out   <= v_ok ? v_sel : '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inner_product_feeder.sv
// Scoreboard bench: SKEW=0 and SKEW=2 feeders share stimulus,
// each checked against a vector-level reference model.
module tb_inner_product_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [31:0] wr_u = '0;
    logic [31:0] wr_v = '0;
    logic        start = 1'b0;

    logic        busy0, done0, uv0, vv0;
    logic        busy2, done2, uv2, vv2;
    logic [31:0] uo0, vo0, uo2, vo2;

    inner_product_feeder #(.WIDTH(32), .DEPTH(3), .SKEW(0)) d0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_u(wr_u), .wr_v(wr_v), .start(start), .busy(busy0),
        .done(done0), .u_out(uo0), .u_valid(uv0), .v_out(vo0),
        .v_valid(vv0)
    );

    inner_product_feeder #(.WIDTH(32), .DEPTH(3), .SKEW(2)) d2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_u(wr_u), .wr_v(wr_v), .start(start), .busy(busy2),
        .done(done2), .u_out(uo2), .u_valid(uv2), .v_out(vo2),
        .v_valid(vv2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          sk [2] = '{0, 2};
    int          se [2];
    int          dc [2];
    logic [31:0] mu [2][3];
    logic [31:0] mv [2][3];
    exp_t        qu [2][$];
    exp_t        qv [2][$];

    logic [31:0] m_uo [2];
    logic [31:0] m_vo [2];
    logic        m_uv [2];
    logic        m_vv [2];
    logic        m_bz [2];
    logic        m_dn [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int n,
                       input longint got, input longint want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc=%0d: got %0d, want %0d",
                     nm, n, cyc, got, want);
        end
    endtask

    task automatic model_clear();
        for (int n = 0; n < 2; n++) begin
            se[n] = -100;
            dc[n] = -100;
            qu[n].delete();
            qv[n].delete();
            for (int i = 0; i < 3; i++) begin
                mu[n][i] = '0;
                mv[n][i] = '0;
            end
        end
    endtask

    // Reference: idle feeders accept loads; starts queue the whole vector
    // pair with its cycle stamps, v lagging u by the skew.
    task automatic model_edge(input int n, input int e);
        bit idle;
        idle = e > dc[n] + 1;
        if (idle && wr_en && wr_addr < 3) begin
            mu[n][wr_addr] = wr_u;
            mv[n][wr_addr] = wr_v;
        end
        if (idle && start) begin
            se[n] = e;
            dc[n] = e + 3 + sk[n];
            for (int i = 0; i < 3; i++) begin
                qu[n].push_back('{e + i, mu[n][i]});
                qv[n].push_back('{e + sk[n] + i, mv[n][i]});
            end
        end
    endtask

    task automatic step(input logic we, input logic [1:0] a,
                        input logic [31:0] u, input logic [31:0] v,
                        input logic st);
        @(posedge clk);
        #1;
        wr_en   = we;
        wr_addr = a;
        wr_u    = u;
        wr_v    = v;
        start   = st;
        for (int n = 0; n < 2; n++) model_edge(n, cyc + 1);
    endtask

    task automatic idle_for(input int c);
        for (int i = 0; i < c; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic mon(input int n);
        exp_t e;
        if (!rst) begin
            chk("rst_zero", n, {m_uv[n], m_vv[n], m_bz[n], m_dn[n],
                                m_uo[n] != 0, m_vo[n] != 0}, 0);
            return;
        end
        if (m_uv[n]) begin
            if (qu[n].size() == 0) chk("u_extra", n, 1, 0);
            else begin
                e = qu[n].pop_front();
                chk("u_cyc", n, cyc, e.cyc);
                chk("u_val", n, m_uo[n], e.val);
            end
        end else chk("u_zero", n, m_uo[n], 0);
        if (m_vv[n]) begin
            if (qv[n].size() == 0) chk("v_extra", n, 1, 0);
            else begin
                e = qv[n].pop_front();
                chk("v_cyc", n, cyc, e.cyc);
                chk("v_val", n, m_vo[n], e.val);
            end
        end else chk("v_zero", n, m_vo[n], 0);
        chk("busy", n, m_bz[n], (cyc >= se[n]) && (cyc < dc[n]));
        chk("done", n, m_dn[n], cyc == dc[n]);
    endtask

    always @(negedge clk) begin
        m_uo[0] = uo0; m_vo[0] = vo0; m_uv[0] = uv0; m_vv[0] = vv0;
        m_bz[0] = busy0; m_dn[0] = done0;
        m_uo[1] = uo2; m_vo[1] = vo2; m_uv[1] = uv2; m_vv[1] = vv2;
        m_bz[1] = busy2; m_dn[1] = done2;
        for (int n = 0; n < 2; n++) mon(n);
    end

    initial begin
        model_clear();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // directed load u={1,2,3}, v={4,5,6}
        step(1, 0, 1, 4, 0);
        step(1, 1, 2, 5, 0);
        step(1, 2, 3, 6, 0);
        // start, then a write and start mid-stream, start in DONE cycle
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(1, 1, 9, 9, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        idle_for(4);
        step(1, 3, 7, 7, 0);
        step(0, 0, 0, 0, 1);
        idle_for(8);

        // write and start on the same edge
        step(1, 0, 11, 12, 1);
        idle_for(8);

        // asynchronous reset in cycle 2 of a stream
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        chk("pre_rst_busy", 0, busy0, 1);
        chk("pre_rst_busy", 1, busy2, 1);
        rst = 1'b0;
        model_clear();
        #1;
        chk("async_rst", 0, {uv0, vv0, busy0, done0}, 0);
        chk("async_rst", 1, {uv2, vv2, busy2, done2}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(0, 0, 0, 0, 1);
        idle_for(8);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 $urandom, $urandom, $urandom_range(0, 5) == 0);
        end
        idle_for(12);

        for (int n = 0; n < 2; n++)
            chk("leftover", n, qu[n].size() + qv[n].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
